// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcodes, flag bit positions and the
// control/status bundles exchanged between the ALU and its surroundings.
// The multiplier is only built when ALU_MUL_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_RSB = 4'd4,
    OP_MUL = 4'd5,
    OP_AND = 4'd6,
    OP_ORR = 4'd7,
    OP_XOR = 4'd8,
    OP_BIC = 4'd9,
    OP_LSL = 4'd10,
    OP_LSR = 4'd11,
    OP_ASR = 4'd12,
    OP_MOV = 4'd13,
    OP_NOT = 4'd14,
    OP_RSV = 4'd15
  } opcode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  // Control side of a request, independent of the data width.
  typedef struct packed {
    logic       valid;
    opcode_e    oper;
    logic [3:0] flags;
  } alu_in_t;

  // Registered status side of a response.
  typedef struct packed {
    logic       valid;
    logic [3:0] flags;
  } alu_out_t;

  // Opcodes whose result and carry come from the shifter.
  function automatic logic isShiftOp(input opcode_e op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for LSL/LSR/ASR including the shift carry.
// The operand is widened by one bit so the last bit shifted out lands in
// the extra position; oversize amounts then fall out naturally as zero
// (logical) or sign copies (arithmetic).
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  opcode_e            oper_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   amount_i,
  input  logic               carry_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               carry_o
);

  logic [WIDTH:0]        lslExt;
  logic [WIDTH:0]        lsrExt;
  logic signed [WIDTH:0] asrSrc;
  logic signed [WIDTH:0] asrExt;
  logic                  amountZero;

  assign lslExt     = {1'b0, a_i} << amount_i;
  assign lsrExt     = {a_i, 1'b0} >> amount_i;
  assign asrSrc     = {a_i, 1'b0};
  assign asrExt     = asrSrc >>> amount_i;
  assign amountZero = (amount_i == '0);

  // Select the shifted value and carry; a zero amount leaves carry untouched.
  always_comb begin
    result_o = '0;
    carry_o  = carry_i;
    case (oper_i)
      OP_LSL: begin
        result_o = lslExt[WIDTH-1:0];
        carry_o  = amountZero ? carry_i : lslExt[WIDTH];
      end
      OP_LSR: begin
        result_o = lsrExt[WIDTH:1];
        carry_o  = amountZero ? carry_i : lsrExt[0];
      end
      OP_ASR: begin
        result_o = asrExt[WIDTH:1];
        carry_o  = amountZero ? carry_i : asrExt[0];
      end
      default: begin
        result_o = '0;
        carry_o  = carry_i;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU. A request accepted on a clock edge shows up
// on result/flags_out with out_valid high for exactly the following cycle;
// otherwise the last outputs are held. Opcode 5 (MUL) is built only when
// ALU_MUL_EN is defined; without it opcode 5 behaves like the reserved code.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       oper,
  input  logic [3:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic             out_valid
);

  alu_in_t          req;
  alu_out_t         status_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;

  logic [WIDTH-1:0] addA;
  logic [WIDTH-1:0] addB;
  logic             addCin;
  logic [WIDTH:0]   sum;
  logic             addOvf;

  logic [WIDTH-1:0] shiftRes;
  logic             shiftCarry;
  logic             updZN;

  assign req.valid = in_valid;
  assign req.oper  = opcode_e'(oper);
  assign req.flags = flags_in;

  // Map every add/subtract flavour onto one adder: a + b' + cin.
  always_comb begin
    addA   = a;
    addB   = b;
    addCin = 1'b0;
    case (req.oper)
      OP_ADC: addCin = req.flags[FLAG_C];
      OP_SUB: begin
        addB   = ~b;
        addCin = 1'b1;
      end
      OP_SBC: begin
        addB   = ~b;
        addCin = req.flags[FLAG_C];
      end
      OP_RSB: begin
        addA   = b;
        addB   = ~a;
        addCin = 1'b1;
      end
      default: begin
        addA   = a;
        addB   = b;
        addCin = 1'b0;
      end
    endcase
  end

  assign sum    = {1'b0, addA} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
  assign addOvf = (addA[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != addA[WIDTH-1]);

  alu_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .oper_i  (req.oper),
    .a_i     (a),
    .amount_i(b),
    .carry_i (req.flags[FLAG_C]),
    .result_o(shiftRes),
    .carry_o (shiftCarry)
  );

  // Next result and flags; flags default to pass-through, Z/N recomputed
  // for every opcode that produces a real result.
  always_comb begin
    result_d = '0;
    flags_d  = req.flags;
    updZN    = 1'b0;
    case (req.oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        result_d        = sum[WIDTH-1:0];
        flags_d[FLAG_C] = sum[WIDTH];
        flags_d[FLAG_V] = addOvf;
        updZN           = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        result_d = a * b;
        updZN    = 1'b1;
      end
`endif
      OP_AND: begin
        result_d = a & b;
        updZN    = 1'b1;
      end
      OP_ORR: begin
        result_d = a | b;
        updZN    = 1'b1;
      end
      OP_XOR: begin
        result_d = a ^ b;
        updZN    = 1'b1;
      end
      OP_BIC: begin
        result_d = a & ~b;
        updZN    = 1'b1;
      end
      OP_MOV: begin
        result_d = b;
        updZN    = 1'b1;
      end
      OP_NOT: begin
        result_d = ~b;
        updZN    = 1'b1;
      end
      default: begin
        if (isShiftOp(req.oper)) begin
          result_d        = shiftRes;
          flags_d[FLAG_C] = shiftCarry;
          updZN           = 1'b1;
        end else begin
          result_d = '0;
        end
      end
    endcase
    if (updZN) begin
      flags_d[FLAG_Z] = (result_d == '0);
      flags_d[FLAG_N] = result_d[WIDTH-1];
    end
  end

  // Output registers: capture on a request, hold otherwise; reset drops
  // anything in flight and clears the outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      status_q.valid <= req.valid;
      if (req.valid) begin
        result_q       <= result_d;
        status_q.flags <= flags_d;
      end
    end
  end

  assign result    = result_q;
  assign flags_out = status_q.flags;
  assign out_valid = status_q.valid;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the ALU: a vector table applied
// back-to-back, followed by hold and mid-operation reset sequences.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   oper;
  logic [3:0]   flags_in;
  logic [W-1:0] result;
  logic [3:0]   flags_out;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [3:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fin;
    logic [31:0] expRes;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs[$];

  alu #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .oper     (oper),
    .flags_in (flags_in),
    .result   (result),
    .flags_out(flags_out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input string name, input logic [3:0] op, input logic [31:0] va,
                                 input logic [31:0] vb, input logic [3:0] fin,
                                 input logic [31:0] er, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.oper = op; v.a = va; v.b = vb; v.fin = fin;
    v.expRes = er; v.expFlags = ef;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic valid);
    @(negedge clk);
    in_valid = valid;
    oper     = v.oper;
    a        = v.a;
    b        = v.b;
    flags_in = v.fin;
  endtask

  task automatic checkOutput(input string name, input logic expValid,
                             input logic [31:0] expRes, input logic [3:0] expFlags);
    checks++;
    if (out_valid !== expValid || result !== expRes || flags_out !== expFlags) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b result=%h flags=%b, expected valid=%0b result=%h flags=%b",
               name, out_valid, result, flags_out, expValid, expRes, expFlags);
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0] mulFlags;

    // Flags are {N,V,C,Z}.
`ifdef ALU_MUL_EN
    mulFlags = 4'b0001;
`else
    mulFlags = 4'b1000;
`endif
    vecs.push_back(mkVec("add_wrap",   4'd0,  32'hFFFF_FFFF, 32'd1,  4'b0000, 32'h0000_0000, 4'b0011));
    vecs.push_back(mkVec("sub_ovf",    4'd2,  32'h8000_0000, 32'd1,  4'b0000, 32'h7FFF_FFFF, 4'b0110));
    vecs.push_back(mkVec("lsl_1",      4'd10, 32'h8000_0001, 32'd1,  4'b0000, 32'h0000_0002, 4'b0010));
    vecs.push_back(mkVec("asr_40",     4'd12, 32'h8000_0000, 32'd40, 4'b0000, 32'hFFFF_FFFF, 4'b1010));
    vecs.push_back(mkVec("and_zero",   4'd6,  32'h0000_00F0, 32'h0F, 4'b0110, 32'h0000_0000, 4'b0111));
    vecs.push_back(mkVec("mul",        4'd5,  32'h0001_0000, 32'h0001_0000, 4'b1000, 32'h0, mulFlags));
    vecs.push_back(mkVec("adc_cin",    4'd1,  32'd1,         32'd2,  4'b0010, 32'd4,         4'b0000));
    vecs.push_back(mkVec("sbc_nocin",  4'd3,  32'd5,         32'd3,  4'b0000, 32'd1,         4'b0010));
    vecs.push_back(mkVec("rsb_neg",    4'd4,  32'd5,         32'd3,  4'b0000, 32'hFFFF_FFFE, 4'b1000));
    vecs.push_back(mkVec("orr_keepv",  4'd7,  32'h8000_0000, 32'd1,  4'b0100, 32'h8000_0001, 4'b1100));
    vecs.push_back(mkVec("xor_zero",   4'd8,  32'hFF,        32'hFF, 4'b1010, 32'h0,         4'b0011));
    vecs.push_back(mkVec("bic",        4'd9,  32'hFF,        32'h0F, 4'b0000, 32'hF0,        4'b0000));
    vecs.push_back(mkVec("lsr_1",      4'd11, 32'd3,         32'd1,  4'b0000, 32'd1,         4'b0010));
    vecs.push_back(mkVec("lsr_32",     4'd11, 32'h8000_0000, 32'd32, 4'b0000, 32'h0,         4'b0011));
    vecs.push_back(mkVec("lsl_33",     4'd10, 32'hFFFF_FFFF, 32'd33, 4'b0010, 32'h0,         4'b0001));
    vecs.push_back(mkVec("lsl_0",      4'd10, 32'h0000_1234, 32'd0,  4'b0110, 32'h0000_1234, 4'b0110));
    vecs.push_back(mkVec("asr_4",      4'd12, 32'h8000_0000, 32'd4,  4'b0000, 32'hF800_0000, 4'b1000));
    vecs.push_back(mkVec("mov_zero",   4'd13, 32'h1234,      32'd0,  4'b1110, 32'h0,         4'b0111));
    vecs.push_back(mkVec("not_zero",   4'd14, 32'h1234,      32'd0,  4'b0000, 32'hFFFF_FFFF, 4'b1000));
    vecs.push_back(mkVec("reserved",   4'd15, 32'd5,         32'd6,  4'b1011, 32'h0,         4'b1011));
    vecs.push_back(mkVec("add_ovf",    4'd0,  32'h7FFF_FFFF, 32'd1,  4'b0000, 32'h8000_0000, 4'b1100));
    vecs.push_back(mkVec("lsl_32",     4'd10, 32'd1,         32'd32, 4'b0000, 32'h0,         4'b0011));
    vecs.push_back(mkVec("asr_100pos", 4'd12, 32'h7000_0000, 32'd100, 4'b0010, 32'h0,        4'b0001));
    vecs.push_back(mkVec("sub_equal",  4'd2,  32'd3,         32'd3,  4'b0000, 32'h0,         4'b0011));

    rst_n = 1'b0; in_valid = 1'b0; oper = '0; a = '0; b = '0; flags_in = '0;
    #1 checkOutput("reset_state", 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset_hold", 1'b0, 32'h0, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("idle_after_reset", 1'b0, 32'h0, 4'h0);

    // Vector table, issued on consecutive cycles.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1);
      if (i == 0) begin
        #1 checkOutput("before_first_edge", 1'b0, 32'h0, 4'h0);
      end
      @(posedge clk);
      #1 checkOutput(vecs[i].name, 1'b1, vecs[i].expRes, vecs[i].expFlags);
    end

    // No request: outputs hold, out_valid drops.
    v = mkVec("idle", 4'd0, 32'h1111_1111, 32'h2222_2222, 4'b1111, 32'h0, 4'h0);
    applyStimulus(v, 1'b0);
    @(posedge clk);
    #1 checkOutput("hold_1", 1'b0, 32'h0, 4'b0011);
    @(posedge clk);
    #1 checkOutput("hold_2", 1'b0, 32'h0, 4'b0011);

    // Reset in the middle of back-to-back traffic.
    v = mkVec("pre_reset_add", 4'd0, 32'd5, 32'd6, 4'b0000, 32'd11, 4'b0000);
    applyStimulus(v, 1'b1);
    @(posedge clk);
    #1 checkOutput("pre_reset_add", 1'b1, 32'd11, 4'b0000);
    v = mkVec("inflight", 4'd0, 32'd1, 32'd1, 4'b0000, 32'd2, 4'b0000);
    applyStimulus(v, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 32'h0, 4'h0);
    @(posedge clk);
    #1 checkOutput("reset_ignores_valid", 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 checkOutput("no_valid_after_release", 1'b0, 32'h0, 4'h0);
    end
    v = mkVec("post_reset_mov", 4'd13, 32'd0, 32'h55, 4'b0000, 32'h55, 4'b0000);
    applyStimulus(v, 1'b1);
    @(posedge clk);
    #1 checkOutput("post_reset_mov", 1'b1, 32'h55, 4'b0000);
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request this cycle.
REQ-005 SHALL have port a  input  WIDTH  first operand.
REQ-006 SHALL have port b  input  WIDTH  second operand / shift amount.
REQ-007 SHALL have port oper  input  4  opcode.
REQ-008 SHALL have port flags_in  input  4  current flags; bit0 Z, bit1 C, bit2 V, bit3 N.
REQ-009 SHALL have port result  output  WIDTH  registered result.
REQ-010 SHALL have port flags_out  output  4  registered flags, same bit order.
REQ-011 SHALL have port out_valid  output  1  result/flags_out valid.

Function
REQ-012 SHALL have one clock, reset asynchronous and active-low.
REQ-013 SHALL register result/flags_out one cycle after an in_valid=1 edge; out_valid=1 for exactly that cycle; back-to-back requests are allowed every cycle.
REQ-014 SHALL hold result/flags_out and drive out_valid=0 in any cycle following in_valid=0.
REQ-015 SHALL implement opcodes: 0 ADD a+b; 1 ADC a+b+C; 2 SUB a+~b+1; 3 SBC a+~b+C; 4 RSB b+~a+1; 5 MUL low WIDTH bits of a*b; 6 AND; 7 ORR; 8 XOR; 9 BIC a&~b; 10 LSL; 11 LSR; 12 ASR; 13 MOV b; 14 NOT ~b; 15 reserved.
REQ-016 SHALL, for opcodes 0-4, set C = carry out of the WIDTH-bit sum (subtract: C=1 means no borrow), V = signed overflow, Z = (result==0), N = result MSB.
REQ-017 SHALL, for opcodes 5-9, 13, 14, update Z and N only; C and V copied from flags_in.
REQ-018 SHALL shift a by the full unsigned value of b; amounts >= WIDTH give 0 (LSL/LSR) or all copies of a's MSB (ASR).
REQ-019 SHALL, for shifts, set C = last bit shifted out (amount > WIDTH: 0 for LSL/LSR, a's MSB for ASR); amount 0: result=a, C unchanged; V always unchanged; Z, N from result.
REQ-020 SHALL, for opcode 15, produce result 0 and flags_out = flags_in.

Reset
REQ-021 SHALL, while rst_n=0, force result=0, flags_out=0, out_valid=0 immediately, regardless of clk.
REQ-022 SHALL discard any request in flight when reset asserts; first valid output after release needs a new in_valid.

Configuration
REQ-023 SHALL implement MUL (opcode 5) only when macro ALU_MUL_EN is defined.
REQ-024 SHALL, without ALU_MUL_EN, treat opcode 5 exactly as opcode 15 (result 0, flags pass through) and instantiate no multiplier.

Structure
REQ-025 SHALL place the opcode enum, flag bit-index constants (FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3) and input/output structs in shared package alu_pkg.
REQ-026 SHALL isolate LSL/LSR/ASR and shift carry in combinational sub-module alu_shifter; the rest stays in alu.

Verification
REQ-027 SHALL test ADD a=0xFFFFFFFF b=1 -> result 0, Z=1 C=1 V=0 N=0, out_valid one cycle later.
REQ-028 SHALL test SUB a=0x80000000 b=1 -> result 0x7FFFFFFF, C=1 V=1 N=0 Z=0.
REQ-029 SHALL test LSL a=0x80000001 b=1 -> result 0x00000002, C=1; ASR a=0x80000000 b=40 -> 0xFFFFFFFF, C=1.
REQ-030 SHALL test AND a=0xF0 b=0x0F with flags_in=0b0110 -> result 0, flags_out=0b0111.
REQ-031 SHALL test MUL a=0x10000 b=0x10000 -> result 0 with Z=1 (ALU_MUL_EN) or 0 with flags_out=flags_in (without).
REQ-032 SHALL test rst_n low mid-operation -> outputs 0 immediately, no out_valid after release until next in_valid.
